mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO register pair.
//  HI/LO feed the 32-bit 2:1 select mux ahead of the EX/MEM register (MFHI/MFLO path).

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_calc.sv | 36 +++
 rtl/mult_div_unit.sv | 74 +++++++
 tb/tb_mult_div_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode/state encodings and counter sizing shared by the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;
  typedef enum logic {MDU_IDLE = 1'b0, MDU_RUN = 1'b1} mdu_state_e;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;
  function automatic int mdu_cnt_w(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational {hi,lo} for MULT/MULTU/DIV/DIVU; divide-by-zero flag exported under MDU_DIVZERO_EN
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res
`ifdef MDU_DIVZERO_EN
  ,output logic       o_dz
`endif
);
  logic w_div, w_sgn, w_bz, w_na, w_nb;
  logic [31:0] w_ma, w_mb, w_uq, w_ur, w_q, w_r;
  logic [63:0] w_ps, w_pu;
  // Division runs on magnitudes so 0x80000000 / -1 folds to 0x80000000 with no overflow
  always_comb begin
    w_div = i_op[1];
    w_sgn = !i_op[0];
    w_bz = i_b == '0;
    w_na = w_sgn & i_a[31];
    w_nb = w_sgn & i_b[31];
    w_ma = w_na ? -i_a : i_a;
    w_mb = w_nb ? -i_b : i_b;
    w_uq = w_bz ? '0 : w_ma / w_mb;
    w_ur = w_bz ? '0 : w_ma % w_mb;
    w_q = (w_na ^ w_nb) ? -w_uq : w_uq;
    w_r = w_na ? -w_ur : w_ur;
    w_ps = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    w_pu = {32'd0, i_a} * {32'd0, i_b};
    o_res = !w_div ? (w_sgn ? w_ps : w_pu) : w_bz ? {i_a, 32'hFFFF_FFFF} : {w_r, w_q};
  end
`ifdef MDU_DIVZERO_EN
  assign o_dz = w_div & w_bz;
`endif
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MDU owning HI/LO; MDU_DIVZERO_EN adds div_zero and suppresses divide-by-zero commits
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
`ifdef MDU_DIVZERO_EN
  ,output logic       div_zero
`endif
);
  localparam int CW = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);
  mdu_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic r_busy;
  logic [63:0] w_res;
  logic w_idle, w_acc, w_last, w_commit;
  assign w_idle = r_state == MDU_IDLE;
  assign w_acc = start && w_idle && md_op <= MDU_DIVU;
  assign w_last = r_state == MDU_RUN && r_cnt == '0;
  assign HI = r_hi;
  assign LO = r_lo;
  assign busy = r_busy;
`ifdef MDU_DIVZERO_EN
  logic w_dz, r_dz;
  mdu_calc u_calc (.i_op(r_op), .i_a(r_a), .i_b(r_b), .o_res(w_res), .o_dz(w_dz));
  assign w_commit = !w_dz;
  assign div_zero = r_dz;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_dz <= 1'b0;
    else if (w_acc) r_dz <= 1'b0;
    else if (w_last) r_dz <= w_dz;
`else
  mdu_calc u_calc (.i_op(r_op), .i_a(r_a), .i_b(r_b), .o_res(w_res));
  assign w_commit = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= MDU_IDLE;
      r_cnt <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_busy <= 1'b0;
    end else if (w_idle) begin
      if (w_acc) begin
        r_state <= MDU_RUN;
        r_busy <= 1'b1;
        r_cnt <= CW'(md_op[1] ? DIV_CYCLES - 1 : MULT_CYCLES - 1);
        r_op <= md_op[1:0];
        r_a <= A;
        r_b <= B;
      end
      if (start && md_op == MDU_MTHI) r_hi <= A;
      if (start && md_op == MDU_MTLO) r_lo <= A;
    end else if (w_last) begin
      r_state <= MDU_IDLE;
      r_busy <= 1'b0;
      if (w_commit) {r_hi, r_lo} <= w_res;
    end else r_cnt <= r_cnt - 1'b1;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized MDU bench against a wide-arithmetic reference model (MDU_DIVZERO_EN aware)
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] md_op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic busy;
`ifdef MDU_DIVZERO_EN
  logic div_zero;
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic m_dz = 1'b0;
  always #5 clk = ~clk;
  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .HI(HI), .LO(LO), .busy(busy)
`ifdef MDU_DIVZERO_EN
    , .div_zero(div_zero)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, " hilo"}, {HI, LO}, {m_hi, m_lo});
`ifdef MDU_DIVZERO_EN
    check({tag, " dz"}, 64'(div_zero), 64'(m_dz));
`endif
  endtask
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 3'd0) return 64'(sa * sb);
    if (op == 3'd1) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 3'd2) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit jam, input string tag);
    logic [63:0] exp;
    int n;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (op >= 3'd4) begin
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      check({tag, " busy"}, 64'(busy), 64'd0);
      check_state(tag);
      return;
    end
    n = op[1] ? DC : MC;
    exp = ref_res(op, a, b);
    m_dz = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, " run busy"}, 64'(busy), 64'd1);
      check_state({tag, " run"});
      if (jam) begin
        start = 1'b1;
        md_op = k == 0 ? 3'd4 : 3'($urandom_range(0, 7));
        A = k == 0 ? 32'h1234 : $urandom;
        B = $urandom;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
`ifdef MDU_DIVZERO_EN
    if (op[1] && b == 32'd0) m_dz = 1'b1;
    else {m_hi, m_lo} = exp;
`else
    {m_hi, m_lo} = exp;
`endif
    check({tag, " done busy"}, 64'(busy), 64'd0);
    check_state({tag, " done"});
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst held busy", 64'(busy), 64'd0);
    check_state("rst held");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst rel busy", 64'(busy), 64'd0);
    check_state("rst rel");
    @(negedge clk);
    start = 1'b1;
    md_op = 3'd0;
    A = 32'd3;
    B = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("rstrun busy", 64'(busy), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rstrun abort busy", 64'(busy), 64'd0);
    check_state("rstrun abort");
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    run_op(3'd3, 32'd7, 32'd2, 1'b0, "divu");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
    run_op(3'd2, 32'd100, 32'd7, 1'b1, "div jam");
    run_op(3'd4, 32'h1234, 32'd0, 1'b0, "mthi");
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");
    run_op(3'd2, 32'd5, 32'd0, 1'b0, "div0");
    run_op(3'd0, 32'd6, 32'd7, 1'b1, "b2b0");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, "divu0");
    run_op(3'd6, 32'h5555_5555, 32'd1, 1'b0, "rsv6");
    run_op(3'd7, 32'hAAAA_AAAA, 32'd1, 1'b0, "rsv7");
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15)) - 32'd8;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)), "rand");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    check("rst final busy", 64'(busy), 64'd0);
    check_state("rst final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
